// File: rtl/dct_pkg.sv
// Shared widths, FSM state type and 8x8 DCT coefficient table for the DCT multiplier stage.
package dct_pkg;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned PROD_W  = 14;
  localparam int unsigned COEF_W  = 6;
  localparam int unsigned ROW_LEN = 8;
  localparam int unsigned X_W     = PIX_W + 1;
  localparam int unsigned K_W     = $clog2(ROW_LEN);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [X_W-1:0]    samp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // C[k][i] = round(31 * a(k) * cos((2i+1) k pi / 16)), a(0) = 1/sqrt(2), a(k>0) = 1
  localparam coef_t COEF_TAB [ROW_LEN][ROW_LEN] = '{
    '{ 6'sd22,  6'sd22,  6'sd22,  6'sd22,  6'sd22,  6'sd22,  6'sd22,  6'sd22},
    '{ 6'sd30,  6'sd26,  6'sd17,  6'sd6,  -6'sd6,  -6'sd17, -6'sd26, -6'sd30},
    '{ 6'sd29,  6'sd12, -6'sd12, -6'sd29, -6'sd29, -6'sd12,  6'sd12,  6'sd29},
    '{ 6'sd26, -6'sd6,  -6'sd30, -6'sd17,  6'sd17,  6'sd30,  6'sd6,  -6'sd26},
    '{ 6'sd22, -6'sd22, -6'sd22,  6'sd22,  6'sd22, -6'sd22, -6'sd22,  6'sd22},
    '{ 6'sd17, -6'sd30,  6'sd6,   6'sd26, -6'sd26, -6'sd6,   6'sd30, -6'sd17},
    '{ 6'sd12, -6'sd29,  6'sd29, -6'sd12, -6'sd12,  6'sd29, -6'sd29,  6'sd12},
    '{ 6'sd6,  -6'sd17,  6'sd26, -6'sd30,  6'sd30, -6'sd26,  6'sd17, -6'sd6 }
  };
endpackage

// File: rtl/dct_coef_rom.sv
// Combinational lookup of the eight coefficients for DCT index k.
module dct_coef_rom
  import dct_pkg::*;
(
  input  logic [K_W-1:0] k,
  output coef_t          coef [ROW_LEN]
);

  // Select one row of the coefficient table
  always_comb begin
    for (int unsigned i = 0; i < ROW_LEN; i++) begin
      coef[i] = COEF_TAB[k][i];
    end
  end

endmodule

// File: rtl/dct_mult8.sv
// Row loader plus 8-way coefficient multiplier feeding an 8-input DCT adder.
// A row of 8 pixels is double-buffered; each row yields 8 product sets (k = 0..7).
module dct_mult8
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              stall,
  output logic [PROD_W-1:0] n0,
  output logic [PROD_W-1:0] n1,
  output logic [PROD_W-1:0] n2,
  output logic [PROD_W-1:0] n3,
  output logic [PROD_W-1:0] n4,
  output logic [PROD_W-1:0] n5,
  output logic [PROD_W-1:0] n6,
  output logic [PROD_W-1:0] n7,
  output logic [K_W-1:0]    k_out,
  output logic              out_valid
);

  localparam logic [K_W-1:0] K_MAX = K_W'(ROW_LEN - 1);

  samp_t          ld_buf [ROW_LEN];
  samp_t          cb     [ROW_LEN];
  logic [K_W-1:0] ld_cnt;
  logic           full;
  state_t         state, state_nx;
  logic [K_W-1:0] k, k_nx;
  coef_t          coef   [ROW_LEN];
  prod_t          prod   [ROW_LEN];
  prod_t          prod_q [ROW_LEN];
  samp_t          x_in;
  logic           accept, last_pix, can_xfer, xfer;

  assign x_in      = $signed({1'b0, pix} - 9'd128);
  assign pix_ready = !full;
  assign accept    = pix_valid && !full;
  assign last_pix  = accept && (ld_cnt == K_MAX);
  assign can_xfer  = (state == ST_IDLE) || ((k == K_MAX) && !stall);
  // A waiting full row and a freshly completed row are mutually exclusive
  assign xfer      = can_xfer && (full || last_pix);

  dct_coef_rom u_rom (
    .k    (k),
    .coef (coef)
  );

  // Load buffer: collect pixels, park a completed row while compute is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      full   <= 1'b0;
      for (int unsigned i = 0; i < ROW_LEN; i++) ld_buf[i] <= '0;
    end else begin
      if (accept) begin
        ld_buf[ld_cnt] <= x_in;
        ld_cnt         <= ld_cnt + 1'b1;
      end
      if (last_pix && !can_xfer) full <= 1'b1;
      else if (xfer)             full <= 1'b0;
    end
  end

  // Compute buffer: the 8th pixel bypasses the load buffer on a direct transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROW_LEN; i++) cb[i] <= '0;
    end else if (xfer) begin
      for (int unsigned i = 0; i < ROW_LEN; i++) begin
        cb[i] <= (last_pix && (i == ROW_LEN - 1)) ? x_in : ld_buf[i];
      end
    end
  end

  // Compute FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // Compute FSM next state: step k while not stalled, restart on back-to-back rows
  always_comb begin
    state_nx = state;
    k_nx     = k;
    unique case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nx = ST_RUN;
          k_nx     = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (k == K_MAX) begin
            k_nx     = '0;
            state_nx = xfer ? ST_RUN : ST_IDLE;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Products are exact in 14 bits: |x| <= 128, |C| <= 31
  always_comb begin
    for (int unsigned i = 0; i < ROW_LEN; i++) begin
      prod[i] = prod_t'(cb[i]) * prod_t'(coef[i]);
    end
  end

  // Output registers: frozen under stall, valid only while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROW_LEN; i++) prod_q[i] <= '0;
      k_out     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (state == ST_RUN) begin
        for (int unsigned i = 0; i < ROW_LEN; i++) prod_q[i] <= prod[i];
        k_out     <= k;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign n0 = prod_q[0];
  assign n1 = prod_q[1];
  assign n2 = prod_q[2];
  assign n3 = prod_q[3];
  assign n4 = prod_q[4];
  assign n5 = prod_q[5];
  assign n6 = prod_q[6];
  assign n7 = prod_q[7];

endmodule

// File: tb/tb_dct_mult8.sv
// Self-checking bench for dct_mult8: directed scenarios plus randomized traffic
// checked against a row-level DCT product model.
module tb_dct_mult8;
  logic        clk = 1'b0;
  logic        rst, pix_valid, stall, pix_ready, out_valid;
  logic [7:0]  pix;
  logic [13:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic [2:0]  k_out;
  logic [13:0] nv [8];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          pq[$];
  int          exp_q[$];
  int          coef_tab [8][8];
  int          cyc_n = 0;
  int          stall_from = -1, stall_to = -1;
  logic        rnd_stall = 1'b0;
  logic [13:0] prev_n [8];
  logic [2:0]  prev_k;
  logic        prev_v;
  int          vcount, vfirst, vlast;

  always #5 clk = ~clk;

  dct_mult8 dut (
    .clk(clk), .rst(rst), .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .stall(stall), .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6),
    .n7(n7), .k_out(k_out), .out_valid(out_valid)
  );

  always_comb begin
    nv[0] = n0; nv[1] = n1; nv[2] = n2; nv[3] = n3;
    nv[4] = n4; nv[5] = n5; nv[6] = n6; nv[7] = n7;
  end

  function automatic int ref_coef(input int k, input int i);
    real a, c;
    a = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    c = 31.0 * a * $cos((2 * i + 1) * k * 3.14159265358979 / 16.0);
    if (c >= 0.0) return $rtoi(c + 0.5);
    return -$rtoi(-c + 0.5);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic save_prev();
    for (int i = 0; i < 8; i++) prev_n[i] = nv[i];
    prev_k = k_out;
    prev_v = out_valid;
  endtask

  // Compares outputs after an edge: frozen under stall, else next expected set
  task automatic monitor(input logic st);
    int same;
    if (st) begin
      same = (k_out === prev_k && out_valid === prev_v) ? 1 : 0;
      for (int i = 0; i < 8; i++) if (nv[i] !== prev_n[i]) same = 0;
      chk("stall_hold", same, 1);
    end else if (out_valid) begin
      vcount++;
      if (vfirst < 0) vfirst = cyc_n;
      vlast = cyc_n;
      chk("valid_expected", int'(exp_q.size() >= 9), 1);
      if (exp_q.size() >= 9) begin
        chk("k_out", int'(k_out), exp_q.pop_front());
        for (int i = 0; i < 8; i++)
          chk($sformatf("n%0d", i), int'($signed(nv[i])), exp_q.pop_front());
      end
    end
    save_prev();
  endtask

  task automatic cyc();
    logic acc, st;
    stall = rnd_stall || (cyc_n >= stall_from && cyc_n < stall_to);
    acc = pix_valid && pix_ready;
    st  = stall;
    @(posedge clk); #1;
    cyc_n++;
    if (acc) begin
      pq.push_back(int'(pix) - 128);
      if (pq.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back(k);
          for (int i = 0; i < 8; i++) exp_q.push_back(pq[i] * coef_tab[k][i]);
        end
        pq.delete();
      end
    end
    monitor(st);
  endtask

  task automatic send(input logic [7:0] p);
    logic ok;
    int   done;
    done = 0;
    pix = p;
    pix_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      ok = pix_ready;
      cyc();
      if (ok) begin done = 1; break; end
    end
    chk("send_accepted", done, 1);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && out_valid == 1'b0) break;
      cyc();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_n%0d", i), int'(nv[i]), 0);
    chk("rst_k_out", int'(k_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pix_ready", int'(pix_ready), 1);
    pq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    save_prev();
  endtask

  task automatic clear_counts();
    vcount = 0; vfirst = -1; vlast = -1;
  endtask

  initial begin
    rst = 1'b0; pix = '0; pix_valid = 1'b0; stall = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) coef_tab[k][i] = ref_coef(k, i);
    #1;
    do_reset();

    // Mid-grey row: eight zero product sets, k 0..7
    clear_counts();
    for (int i = 0; i < 8; i++) send(8'd128);
    drain();
    chk("grey_valid_cycles", vcount, 8);
    chk("grey_valid_run", vlast - vfirst + 1, 8);

    // White row: k=0 latency one edge after transfer, then k=1
    for (int i = 0; i < 8; i++) send(8'd255);
    cyc();
    chk("white_ov", int'(out_valid), 1);
    chk("white_k0", int'(k_out), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("white_k0_n%0d", i), int'(nv[i]), 'h0AEA);
    cyc();
    chk("white_k1_n0", int'(n0), 'h0EE2);
    drain();

    // Black row: most negative k=0 product
    for (int i = 0; i < 8; i++) send(8'd0);
    cyc();
    chk("black_k0", int'(k_out), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("black_k0_n%0d", i), int'(nv[i]), 'h3500);
    drain();

    // Three rows streamed back-to-back
    clear_counts();
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom_range(0, 255)));
      chk("stream_ready", int'(pix_ready), 1);
    end
    drain();
    chk("stream_valid_cycles", vcount, 24);
    chk("stream_valid_run", vlast - vfirst + 1, 24);

    // Stall during row 1 while row 2 fills the load buffer
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
    stall_from = cyc_n + 1;
    stall_to   = stall_from + 10;
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
    chk("stall_full_ready", int'(pix_ready), 0);
    drain();
    stall_from = -1; stall_to = -1;
    chk("stall_ready_back", int'(pix_ready), 1);

    // Partial row discarded by reset
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
    do_reset();
    for (int i = 0; i < 8; i++) send(8'd255);
    cyc();
    chk("post_rst_k0", int'(k_out), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("post_rst_n%0d", i), int'(nv[i]), 2794);
    drain();

    // Random traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      pix       = 8'($urandom_range(0, 255));
      pix_valid = ($urandom_range(0, 3) != 0);
      rnd_stall = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rnd_stall = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_mult8.md
DCT_MULT8 -- requirements
Module: dct_mult8

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-003 SHALL have port pix, input, 8, unsigned pixel sample.
REQ-004 SHALL have port pix_valid, input, 1, pix is presented this cycle.
REQ-005 SHALL have port pix_ready, output, 1, block accepts pix this cycle.
REQ-006 SHALL have port stall, input, 1, freezes compute pipeline and outputs.
REQ-007 SHALL have ports n0..n7, output, 14 each, signed two's-complement products feeding the 8-input DCT adder.
REQ-008 SHALL have port k_out, output, 3, DCT coefficient index of current n0..n7.
REQ-009 SHALL have port out_valid, output, 1, n0..n7/k_out hold a valid product set.

Function
REQ-010 SHALL accept a pixel on any rising edge where pix_valid=1 and pix_ready=1; pixel i (0..7 in arrival order) is stored as x_i = pix - 128 (signed 9-bit).
REQ-011 SHALL hold a load buffer (8 x 9-bit, load count 0..7) and a compute buffer (8 x 9-bit).
REQ-012 SHALL transfer the row into the compute buffer at the edge accepting the 8th pixel (including that pixel), reset load count to 0, when compute FSM is IDLE or in RUN with k=7 and stall=0.
REQ-013 SHALL otherwise set a FULL flag, drive pix_ready=0, and transfer at the first edge where REQ-012's condition holds, then clear FULL.
REQ-014 SHALL drive pix_ready = !FULL.
REQ-015 SHALL run compute FSM IDLE -> RUN on transfer; in RUN, k steps 0..7, one step per edge with stall=0; at k=7 go to IDLE, or restart at k=0 if a transfer occurs that edge.
REQ-016 SHALL register n_i = x_i * C[k][i] with C[k][i] = round(31*a(k)*cos((2i+1)k*pi/16)), a(0)=1/sqrt2, a(k>0)=1; coefficients signed 6-bit, |C|<=31.
REQ-017 SHALL sign-extend products to 14 bits exactly (range -3968..3968, no saturation or truncation).
REQ-018 SHALL present k=0 products with out_valid=1 after the edge following transfer; k=7 after the 8th such edge; zero-bubble back-to-back rows.
REQ-019 SHALL, with stall=1, hold n0..n7, k_out, out_valid and FSM state; pixel loading continues until FULL.
REQ-020 SHALL drive out_valid=0 and hold last n0..n7/k_out when IDLE.
REQ-021 SHALL ignore pix when pix_valid=0 (no load count change).

Reset
REQ-022 SHALL on rst=1 immediately clear n0..n7 to 0, k_out to 0, out_valid to 0, load count to 0, FULL to 0, FSM to IDLE; pix_ready=1.
REQ-023 SHALL discard a partially loaded or in-compute row on reset; first row after reset starts at pixel 0.

Structure
REQ-024 SHALL place pixel width (8), product width (14), coefficient width (6), row length (8) and the 8x8 coefficient table in shared package dct_pkg.
REQ-025 SHALL implement coefficient lookup as sub-module dct_coef_rom (input k, output 8 signed coefficients, combinational).

Verification
REQ-026 SHALL check: 8 pixels of 128 -> 8 cycles out_valid=1, all n=0, k_out 0..7.
REQ-027 SHALL check: 8 pixels of 255 -> k=0 all n=2794 (14'h0AEA); k=1 n0=3810 (14'h0EE2).
REQ-028 SHALL check: 8 pixels of 0 -> k=0 all n=-2816 (14'h3500).
REQ-029 SHALL check: 3 rows streamed at one pixel/cycle -> 24 consecutive out_valid cycles, pix_ready constantly 1.
REQ-030 SHALL check: stall=1 for 10 cycles during row 1 while row 2 streams -> pix_ready=0 after row 2's 8th pixel, outputs frozen, no data loss after release.
REQ-031 SHALL check: 5 pixels, rst pulse, then 8 pixels of 255 -> outputs 0 during reset, first row k=0 all n=2794.
